// File: rtl/jpeg_pkg.sv
// Shared types for the JPEG entropy front end: symbol record, FSM states, block constants.
// No logic; sym_t is sized for the default 12-bit coefficient path.
// Backpressure is not applicable here.
package jpeg_pkg;

  localparam int BLOCK_SIZE = 64;
  localparam int ZRL_RUN    = 15;
  localparam int COEF_W     = 12;
  localparam int MAG_W      = COEF_W + 1;
  localparam int SIZE_W     = $clog2(MAG_W + 1);

  typedef struct packed {
    logic [3:0]        run;
    logic [SIZE_W-1:0] size;
    logic [MAG_W-1:0]  amp;
    logic              dc;
    logic              eob;
  } sym_t;

  typedef enum logic [1:0] {
    ST_ACCEPT,
    ST_ZRL,
    ST_SYM,
    ST_EOB
  } state_t;

  // Control symbols (ZRL, EOB) carry no size or amplitude.
  function automatic sym_t ctrl_sym(input logic [3:0] run, input logic eob);
    sym_t s;
    s     = '0;
    s.run = run;
    s.eob = eob;
    return s;
  endfunction

endpackage

// File: rtl/lead_nz.sv
// Leading-zero counter; returns DATA_WIDTH for an all-zero input.
// Purely combinational, zero latency.
// No flow control.
module lead_nz #(
  parameter  int DATA_WIDTH = 13,
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [CNT_WIDTH-1:0]  count
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = CNT_WIDTH'(DATA_WIDTH);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (data[i]) count = CNT_WIDTH'(DATA_WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/rle_size_ctrl.sv
// Zig-zag coefficients to JPEG (RUN, SIZE, AMP) symbols with DC differencing, ZRL and EOB insertion.
// Latency: a symbol is registered one cycle after its coefficient is accepted.
// Backpressure: single output register; input stalls while it is full and not drained, and during ZRL bursts.
module rle_size_ctrl
  import jpeg_pkg::*;
#(
  parameter  int COEF_WIDTH = COEF_W,
  localparam int MAG_WIDTH  = COEF_WIDTH + 1,
  localparam int SIZE_WIDTH = $clog2(MAG_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [COEF_WIDTH-1:0] in_data,
  input  logic                  in_sof,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_run,
  output logic [SIZE_WIDTH-1:0] out_size,
  output logic [MAG_WIDTH-1:0]  out_amp,
  output logic                  out_dc,
  output logic                  out_eob
);

  localparam logic [5:0] LAST_IDX = 6'(BLOCK_SIZE - 1);

  state_t                state;
  logic [5:0]            idx;
  logic [5:0]            zrun;
  logic [1:0]            zrl_left;
  logic [COEF_WIDTH-1:0] pred;
  sym_t                  out_q;
  sym_t                  pend;
  logic                  out_valid_q;

  logic                  out_free;
  logic                  accept;
  logic                  is_dc;
  logic                  is_last;
  logic                  nonzero;
  logic [COEF_WIDTH-1:0] pred_eff;
  logic [MAG_WIDTH-1:0]  coef_x;
  logic [MAG_WIDTH-1:0]  pred_x;
  logic [MAG_WIDTH-1:0]  value;
  logic [MAG_WIDTH-1:0]  mag;
  logic [MAG_WIDTH-1:0]  amp_raw;
  logic [SIZE_WIDTH-1:0] nz;
  logic [SIZE_WIDTH-1:0] size;
  sym_t                  cur_sym;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = !rst && (state == ST_ACCEPT) && out_free;
  assign accept   = in_valid && in_ready;
  assign is_dc    = (idx == 6'd0);
  assign is_last  = (idx == LAST_IDX);
  assign nonzero  = |in_data;

  assign pred_eff = in_sof ? '0 : pred;
  assign coef_x   = {in_data[COEF_WIDTH-1], in_data};
  assign pred_x   = {pred_eff[COEF_WIDTH-1], pred_eff};
  assign value    = is_dc ? (coef_x - pred_x) : coef_x;
  assign mag      = value[MAG_WIDTH-1] ? (~value + MAG_WIDTH'(1)) : value;

  lead_nz #(.DATA_WIDTH(MAG_WIDTH)) u_lead_nz (
    .data  (mag),
    .count (nz)
  );

  assign size    = SIZE_WIDTH'(MAG_WIDTH) - nz;
  assign amp_raw = value[MAG_WIDTH-1] ? (value - MAG_WIDTH'(1)) : value;

  always_comb begin
    cur_sym      = '0;
    cur_sym.run  = is_dc ? 4'd0 : zrun[3:0];
    cur_sym.size = size;
    cur_sym.amp  = amp_raw & ~({MAG_WIDTH{1'b1}} << size);
    cur_sym.dc   = is_dc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ACCEPT;
      idx         <= '0;
      zrun        <= '0;
      zrl_left    <= '0;
      pred        <= '0;
      out_q       <= '0;
      pend        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_ACCEPT: begin
          if (out_ready) out_valid_q <= 1'b0;
          if (accept) begin
            idx <= idx + 6'd1;
            if (is_dc) begin
              pred        <= in_data;
              zrun        <= '0;
              out_q       <= cur_sym;
              out_valid_q <= 1'b1;
            end else if (nonzero) begin
              zrun        <= '0;
              out_valid_q <= 1'b1;
              // First ZRL goes out now; the coefficient's own symbol waits in pend.
              if (zrun[5:4] != 2'd0) begin
                pend     <= cur_sym;
                out_q    <= ctrl_sym(4'(ZRL_RUN), 1'b0);
                zrl_left <= zrun[5:4] - 2'd1;
                state    <= (zrun[5:4] == 2'd1) ? ST_SYM : ST_ZRL;
              end else begin
                out_q <= cur_sym;
              end
            end else if (is_last) begin
              zrun        <= '0;
              out_q       <= ctrl_sym(4'd0, 1'b1);
              out_valid_q <= 1'b1;
            end else begin
              zrun <= zrun + 6'd1;
            end
          end
        end
        ST_ZRL: begin
          if (out_free) begin
            out_q       <= ctrl_sym(4'(ZRL_RUN), 1'b0);
            out_valid_q <= 1'b1;
            zrl_left    <= zrl_left - 2'd1;
            if (zrl_left == 2'd1) state <= ST_SYM;
          end
        end
        ST_SYM: begin
          if (out_free) begin
            out_q       <= pend;
            out_valid_q <= 1'b1;
            state       <= ST_ACCEPT;
          end
        end
        ST_EOB: begin
          if (out_free) begin
            out_q       <= ctrl_sym(4'd0, 1'b1);
            out_valid_q <= 1'b1;
            state       <= ST_ACCEPT;
          end
        end
        default: state <= ST_ACCEPT;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_run   = out_q.run;
  assign out_size  = out_q.size;
  assign out_amp   = out_q.amp;
  assign out_dc    = out_q.dc;
  assign out_eob   = out_q.eob;

endmodule
